// File: rtl/mdu_pkg.sv
// mdu_pkg: shared FSM state, op encodings and step-count constants for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU = 1'b1;
    localparam int MDU_STEPS = 32;
    localparam int CNT_W = 6;
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: N-bit add/subtract with carry-out; on subtract, carry=1 means x >= y
module mdu_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] yy;
    assign yy = sub ? ~y : y;
    assign {cout, sum} = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, sub};
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: 32-step iterative MULTU/DIVU sequencer driving the HI/LO registers
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    import mdu_pkg::*;
    state_t state, state_n;
    logic [2*WIDTH:0] acc, acc_n;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0] x, sum;
    logic op_r, cout, last, load;
    assign last = cnt == CNT_W'(MDU_STEPS - 1);
    assign load = state != RUN && state_n == RUN;
    // divide trial-subtracts the already-shifted remainder; multiply adds into the unshifted upper half
    assign x = op_r == OP_DIVU ? acc[2*WIDTH-1:WIDTH-1] : acc[2*WIDTH:WIDTH];
    mdu_addsub #(.N(WIDTH + 1)) u_addsub (
        .x    (x),
        .y    ({1'b0, m}),
        .sub  (op_r == OP_DIVU),
        .sum  (sum),
        .cout (cout)
    );
    always_comb begin
        acc_n = {1'b0, acc[0] ? sum : acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
        if (op_r == OP_DIVU)
            acc_n = cout ? {sum, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-1:0], 1'b0};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = (start && !abort) ? RUN : IDLE;
        if (state == RUN)
            state_n = abort ? IDLE : last ? DONE : RUN;
    end
    always_comb begin
        busy  = state == RUN;
        done  = state == DONE;
        stall = (busy | start) & hilo_rd;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_r <= 1'b0;
            m    <= '0;
            acc  <= '0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (load) begin
                op_r <= op;
                m    <= op == OP_DIVU ? b : a;
                acc  <= {{(WIDTH + 1){1'b0}}, op == OP_DIVU ? a : b};
                cnt  <= '0;
            end else if (state == RUN) begin
                acc <= acc_n;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == RUN && state_n == DONE) begin
                hi <= acc_n[2*WIDTH-1:WIDTH];
                lo <= acc_n[WIDTH-1:0];
            end
        end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic abort = 1'b0;
    logic hilo_rd = 1'b0;
    logic [31:0] hi, lo;
    logic busy, done, stall;
    int vec = 0;
    int miss = 0;
    int nb;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .hilo_rd (hilo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(busy);
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go(1'b0, 32'd7, 32'd6);
        wait_done(nb);
        chk("mul7x6 busy cycles", 32'(nb), 32'd32);
        chk("mul7x6 done", 32'(done), 32'd1);
        chk("mul7x6 busy in done", 32'(busy), 32'd0);
        chk("mul7x6 hi", hi, 32'd0);
        chk("mul7x6 lo", lo, 32'd42);
        @(negedge clk);
        chk("mul7x6 done drops", 32'(done), 32'd0);
        chk("mul7x6 lo holds", lo, 32'd42);

        go(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        hilo_rd = 1'b1;
        #1 chk("stall in run", 32'(stall), 32'd1);
        hilo_rd = 1'b0;
        wait_done(nb);
        hilo_rd = 1'b1;
        #1 chk("stall in done", 32'(stall), 32'd0);
        chk("mulmax hi", hi, 32'hFFFF_FFFE);
        chk("mulmax lo", lo, 32'h0000_0001);
        hilo_rd = 1'b0;
        @(negedge clk);

        go(1'b1, 32'd100, 32'd7);
        wait_done(nb);
        chk("div100/7 done", 32'(done), 32'd1);
        chk("div100/7 lo", lo, 32'd14);
        chk("div100/7 hi", hi, 32'd2);
        @(negedge clk);

        go(1'b1, 32'd5, 32'd0);
        wait_done(nb);
        chk("div5/0 lo", lo, 32'hFFFF_FFFF);
        chk("div5/0 hi", hi, 32'd5);
        @(negedge clk);

        go(1'b0, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            nb += int'(done);
            @(negedge clk);
        end
        chk("abort no done", 32'(nb), 32'd0);
        chk("abort hi kept", hi, 32'd5);
        chk("abort lo kept", lo, 32'hFFFF_FFFF);

        start = 1'b1;
        abort = 1'b1;
        hilo_rd = 1'b1;
        #1 chk("stall start idle", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1 chk("stall idle no start", 32'(stall), 32'd0);
        hilo_rd = 1'b0;
        chk("abort beats start", 32'(busy), 32'd0);

        go(1'b0, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        chk("ignored start done", 32'(done), 32'd1);
        chk("ignored start hi", hi, 32'd0);
        chk("ignored start lo", lo, 32'd12);
        @(negedge clk);
        chk("no queued op", 32'(busy), 32'd0);

        go(1'b0, 32'd2, 32'd3);
        wait_done(nb);
        chk("mul2x3 lo", lo, 32'd6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort in done lo", lo, 32'd6);
        chk("abort in done hi", hi, 32'd0);
        chk("abort in done busy", 32'(busy), 32'd0);

        go(1'b1, 32'd9, 32'd2);
        wait_done(nb);
        chk("div9/2 lo", lo, 32'd4);
        chk("div9/2 hi", hi, 32'd1);
        go(1'b0, 32'd5, 32'd5);
        chk("back-to-back busy", 32'(busy), 32'd1);
        wait_done(nb);
        chk("back-to-back busy cycles", 32'(nb), 32'd32);
        chk("back-to-back done", 32'(done), 32'd1);
        chk("mul5x5 lo", lo, 32'd25);
        @(negedge clk);

        go(1'b1, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(1'b1, 32'd9, 32'd3);
        wait_done(nb);
        chk("div9/3 done", 32'(done), 32'd1);
        chk("div9/3 lo", lo, 32'd3);
        chk("div9/3 hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
